freq_ascii_framer: RTL

// - Converts the cymometer's binary frequency result into an 11-byte ASCII frame for the UART transmitter.
// - Sits between cymometer (data_fx) and uart_transfer (txd_data/txd_en), in the clk_200MHZ domain.
// - Samples data_fx every FRAME_PERIOD cycles and converts it to BCD with a sequential double-dabble.
// - Packs the result and pulses txd_en for one cycle.

---
 rtl/freq_ascii_pkg.sv | 19 +
 rtl/bin2bcd_seq.sv | 83 ++++++++
 rtl/freq_ascii_framer.sv | 109 ++++++++++
 3 files changed

// File: rtl/freq_ascii_pkg.sv
// Shared constants and state encoding for the frequency-to-ASCII framer.
package freq_ascii_pkg;

    localparam int unsigned FRAME_BYTES = 11;

    localparam logic [7:0] CH_F  = 8'h46;
    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StPack
    } state_e;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one cycle to arm after start, then DATA_W shift steps.
// done is high during the final step; bcd_out is final from the following cycle.
module bin2bcd_seq #(
    parameter int unsigned DATA_W = 26,
    parameter int unsigned DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_W-1:0]     bin_in,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd_out
);

    localparam int unsigned IterW = $clog2(DATA_W + 1);
    localparam int unsigned BcdW  = DIGITS * 4;

    logic [DATA_W-1:0] bin_q, bin_d;
    logic [BcdW-1:0]   bcd_q, bcd_d, bcd_adj;
    logic [IterW-1:0]  iter_q, iter_d;
    logic              arm_q, arm_d;
    logic              run_q, run_d;
    logic              last_step;

    assign last_step = run_q && (iter_q == IterW'(DATA_W - 1));
    assign done      = last_step;
    assign bcd_out   = bcd_q;

    // Add 3 to every nibble >= 5 ahead of the shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Next-state: load on start, clear counter while armed, then shift {bcd,bin}
    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        iter_d = iter_q;
        arm_d  = arm_q;
        run_d  = run_q;
        if (start) begin
            bin_d  = bin_in;
            bcd_d  = '0;
            iter_d = '0;
            arm_d  = 1'b1;
            run_d  = 1'b0;
        end else if (arm_q) begin
            iter_d = '0;
            arm_d  = 1'b0;
            run_d  = 1'b1;
        end else if (run_q) begin
            bcd_d  = {bcd_adj[BcdW-2:0], bin_q[DATA_W-1]};
            bin_d  = {bin_q[DATA_W-2:0], 1'b0};
            iter_d = iter_q + IterW'(1);
            if (last_step) begin
                run_d = 1'b0;
            end
        end
    end

    // Conversion state registers, synchronous reset aborts any conversion
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            iter_q <= '0;
            arm_q  <= 1'b0;
            run_q  <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            iter_q <= iter_d;
            arm_q  <= arm_d;
            run_q  <= run_d;
        end
    end

endmodule

// File: rtl/freq_ascii_framer.sv
// Periodically samples the measured frequency, converts it to decimal and
// presents an 11-byte ASCII frame ("F" + 8 digits + CR LF) with a one-cycle strobe.
module freq_ascii_framer
    import freq_ascii_pkg::*;
#(
    parameter int unsigned DATA_W       = 26,
    parameter int unsigned DIGITS       = 8,
    parameter int unsigned FRAME_PERIOD = 20_000_000,
    parameter bit          LZ_BLANK     = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        data_fx,
    output logic [FRAME_BYTES*8-1:0] data_uart,
    output logic                     txd_en,
    output logic                     busy
);

    localparam int unsigned CntW   = $clog2(FRAME_PERIOD);
    localparam int unsigned FrameW = FRAME_BYTES * 8;

    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                tick;
    state_e              state_q, state_d;
    logic                conv_start;
    logic                conv_done;
    logic [DIGITS*4-1:0] bcd;
    logic [FrameW-1:0]   frame;
    logic [FrameW-1:0]   data_uart_q;
    logic                txd_en_q;

    assign tick      = (cnt_q == CntW'(FRAME_PERIOD - 1));
    assign busy      = (state_q != StIdle);
    assign data_uart = data_uart_q;
    assign txd_en    = txd_en_q;

    bin2bcd_seq #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (conv_start),
        .bin_in  (data_fx),
        .done    (conv_done),
        .bcd_out (bcd)
    );

    // Free-running sample period counter
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end

    // Sequencer: IDLE -> LOAD -> SHIFT -> PACK; ticks outside IDLE are dropped
    always_comb begin
        state_d    = state_q;
        conv_start = 1'b0;
        case (state_q)
            StIdle: begin
                if (tick) begin
                    conv_start = 1'b1;
                    state_d    = StLoad;
                end
            end
            StLoad:  state_d = StShift;
            StShift: if (conv_done) state_d = StPack;
            StPack:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Frame assembly with optional leading-zero blanking; units digit always shown
    always_comb begin
        logic       seen_nz;
        logic [3:0] nib;
        frame   = '0;
        seen_nz = 1'b0;
        nib     = '0;
        frame[FrameW-1 -: 8] = CH_F;
        frame[15:8]          = CH_CR;
        frame[7:0]           = CH_LF;
        for (int k = 0; k < int'(DIGITS); k++) begin
            nib = bcd[4*(int'(DIGITS)-1-k) +: 4];
            if (nib != 4'd0 || k == int'(DIGITS) - 1) begin
                seen_nz = 1'b1;
            end
            frame[8*(int'(FRAME_BYTES)-2-k) +: 8] =
                (LZ_BLANK && !seen_nz) ? CH_SP : CH_0 + {4'h0, nib};
        end
    end

    // Counter, FSM and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            state_q     <= StIdle;
            data_uart_q <= '0;
            txd_en_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            txd_en_q <= (state_q == StPack);
            if (state_q == StPack) begin
                data_uart_q <= frame;
            end
        end
    end

endmodule
